wb_regfile_queue: RTL
=====================

// Module: wb_regfile_queue
// PURPOSE
//  Write-back stage and register file of the 16-bit CPU, directly downstream of the ALU/SLTI result path.
//  Accepts ALU results (rt/rd plus data) through a valid/ready handshake into a 2-entry write-back queue.
//  Retires one queued write per cycle into a 4 x 16-bit register file; register 0 is hardwired to zero.
//  Read ports feed rs/rt to the ALU (incl. SLTI) with forwarding from pending queue entries.
// PARAMETERS
//  DATA_W  16  register/data width
//  ADDR_W  2   register address width (2**ADDR_W registers)
//  DEPTH   2   write-back queue entries (fixed 2; states below assume it)
// PORTS
//  clk        in   1       rising-edge clock
//  reset      in   1       synchronous, active-high reset
//  in_valid   in   1       ALU result valid
//  in_ready   out  1       queue can accept (= not FULL)
//  in_we      in   1       result writes a register (0: accepted and dropped)
//  in_addr    in   ADDR_W  destination register (rt for I-type, rd for R-type)
//  in_data    in   DATA_W  result value (e.g. SLTI 0/1)
//  wb_hold    in   1       1: block retire this cycle (queue holds)
//  ra_addr    in   ADDR_W  read port A address (rs)
//  ra_data    out  DATA_W  read port A data, combinational
//  rb_addr    in   ADDR_W  read port B address (rt)
//  rb_data    out  DATA_W  read port B data, combinational
//  pending    out  2       queue occupancy 0..2
// BEHAVIOUR
//  - Reset: all registers 0, queue EMPTY, pending=0, in_ready=1; reset mid-operation discards queued writes.
//  - push = in_valid & in_ready & in_we & (in_addr!=0); writes with in_we=0 or in_addr=0 handshake, are not queued.
//  - pop = (pending!=0) & ~wb_hold; the head entry is written to the regfile at that clock edge.
//  - Queue FSM: EMPTY -push-> ONE; ONE -push&~pop-> FULL, -pop&~push-> EMPTY, push&pop-> ONE;
//    FULL -pop-> ONE (in_ready=0 in FULL, so no push); otherwise state holds.
//  - Simultaneous push+pop in ONE: head retires, new entry becomes head; order strictly FIFO.
//  - Latency: accepted write visible in regfile 1 cycle after acceptance (queue) +1 per cycle of wb_hold / older entries.
//  - in_ready combinational from state only (not from in_valid); no combinational path in_valid->in_ready.
//  - Read: addr 0 -> 0. Else youngest matching pending entry, then older entry, then regfile.
//    Same-cycle in_data is NOT forwarded (only entries already queued).
//  - Two pending entries to same register: both retire in order; forwarding returns the younger.
//  - Data width rule: in_data stored unmodified, no sign/zero extension in this block.
//  - pending reflects state after last edge: EMPTY=0, ONE=1, FULL=2.
// TESTING
//  1 reset=1 one cycle -> all reads 0, pending=0, in_ready=1.
//  2 push (addr 1, data 16'd1, SLTI 10<11) wb_hold=0 -> next cycle ra_addr=1 reads 1 via forward, cycle after from regfile, pending 1->0.
//  3 wb_hold=1, push addr2=16'hAAAA then addr2=16'h5555 -> pending=2, in_ready=0, rb_addr=2 reads 16'h5555; release hold -> regfile r2=16'h5555 after 2 pops.
//  4 push addr 0 data 16'hFFFF, we=1 -> handshake completes, pending stays 0, ra_addr=0 reads 0.
//  5 ONE state, wb_hold=0, push addr3=16'd7 same cycle as pop addr1=16'd3 -> pending stays 1, r1=3 then r3=7 next cycle.
//  6 FULL with wb_hold=1, assert reset -> next cycle pending=0, r1..r3=0, queued writes never land.

Source files
------------

// File: rtl/wb_regfile_queue.sv
// Write-back stage: 2-entry FIFO of pending register writes feeding a
// 4x16 register file (r0 hardwired to 0) with forwarding on two read ports.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   ALU result handshake (in_ready = queue not full)
//   in_we/in_addr/in_data
//                       result write enable, destination, value
//   wb_hold             blocks retirement of the queue head this cycle
//   ra_addr/ra_data     read port A (rs), combinational
//   rb_addr/rb_data     read port B (rt), combinational
//   pending             queue occupancy 0..2
module wb_regfile_queue #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 2,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_we,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              wb_hold,
  input  logic [ADDR_W-1:0] ra_addr,
  output logic [DATA_W-1:0] ra_data,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] rb_data,
  output logic [$clog2(DEPTH+1)-1:0] pending
);

  localparam int unsigned NREG  = 1 << ADDR_W;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0] pending_q, pending_d;
  logic             in_ready_q, in_ready_d;

  // Head is the oldest entry; tail is only meaningful in FULL.
  logic [ADDR_W-1:0] head_addr_q, head_addr_d;
  logic [DATA_W-1:0] head_data_q, head_data_d;
  logic [ADDR_W-1:0] tail_addr_q, tail_addr_d;
  logic [DATA_W-1:0] tail_data_q, tail_data_d;

  logic [DATA_W-1:0] rf_q [NREG];
  logic [DATA_W-1:0] rf_d [NREG];

  logic push;
  logic pop;

  // Writes to r0 or with in_we=0 complete the handshake but are dropped.
  assign push = in_valid & in_ready_q & in_we
              & (in_addr != '0);
  assign pop  = (state_q != EMPTY) & ~wb_hold;

  always_comb begin
    state_d     = state_q;
    head_addr_d = head_addr_q;
    head_data_d = head_data_q;
    tail_addr_d = tail_addr_q;
    tail_data_d = tail_data_q;

    unique case (state_q)
      EMPTY: begin
        if (push) begin
          state_d     = ONE;
          head_addr_d = in_addr;
          head_data_d = in_data;
        end
      end
      ONE: begin
        if (push && pop) begin
          // Head retires this edge; new entry takes its slot.
          head_addr_d = in_addr;
          head_data_d = in_data;
        end else if (push) begin
          state_d     = FULL;
          tail_addr_d = in_addr;
          tail_data_d = in_data;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          state_d     = ONE;
          head_addr_d = tail_addr_q;
          head_data_d = tail_data_q;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Outputs registered from the next state so they depend on state only.
  always_comb begin
    pending_d  = '0;
    in_ready_d = 1'b1;
    unique case (state_d)
      EMPTY:   pending_d = CNT_W'(0);
      ONE:     pending_d = CNT_W'(1);
      FULL: begin
        pending_d  = CNT_W'(2);
        in_ready_d = 1'b0;
      end
      default: pending_d = '0;
    endcase
  end

  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      rf_d[i] = rf_q[i];
    end
    if (pop) begin
      rf_d[head_addr_q] = head_data_q;
    end
    rf_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= EMPTY;
      pending_q   <= '0;
      in_ready_q  <= 1'b1;
      head_addr_q <= '0;
      head_data_q <= '0;
      tail_addr_q <= '0;
      tail_data_q <= '0;
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      in_ready_q  <= in_ready_d;
      head_addr_q <= head_addr_d;
      head_data_q <= head_data_d;
      tail_addr_q <= tail_addr_d;
      tail_data_q <= tail_data_d;
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= rf_d[i];
      end
    end
  end

  logic head_vld;
  logic tail_vld;

  assign head_vld = (state_q != EMPTY);
  assign tail_vld = (state_q == FULL);

  // Read priority: r0, younger (tail), older (head), regfile.
  always_comb begin
    ra_data = rf_q[ra_addr];
    if (ra_addr == '0) begin
      ra_data = '0;
    end else if (tail_vld && tail_addr_q == ra_addr) begin
      ra_data = tail_data_q;
    end else if (head_vld && head_addr_q == ra_addr) begin
      ra_data = head_data_q;
    end
  end

  always_comb begin
    rb_data = rf_q[rb_addr];
    if (rb_addr == '0) begin
      rb_data = '0;
    end else if (tail_vld && tail_addr_q == rb_addr) begin
      rb_data = tail_data_q;
    end else if (head_vld && head_addr_q == rb_addr) begin
      rb_data = head_data_q;
    end
  end

  assign in_ready = in_ready_q;
  assign pending  = pending_q;

endmodule
